// File: rtl/led_scan_sched.sv
// led_scan_sched
//   Time-multiplexed scan scheduler for a 4-digit, 7-segment (+dp) display.
//   Each digit gets one slot of SLOT_M clocks. A slot is BLANK_M dark cycles
//   (ghosting guard) followed by SLOT_M-BLANK_M ON cycles. Within ON, an
//   8-cycle PWM sets brightness.
//
// Parameters
//   SLOT_M  : clocks per digit slot, blank time included
//   BLANK_M : blanking clocks at the start of each slot
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   in3..in0   : per-digit segment patterns, active-low, {dp,g,f,e,d,c,b,a}
//   digit_en   : per-digit enable, bit i = digit i
//   bright     : lit for bright+1 of every 8 ON cycles
//   an         : digit anodes, active-low, registered
//   sseg       : segment bus, active-low, registered
//   frame_tick : one-cycle pulse on the first BLANK cycle after digit 3 ON
module led_scan_sched #(
  parameter int SLOT_M  = 50_000,
  parameter int BLANK_M = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in3,
  input  logic [7:0] in2,
  input  logic [7:0] in1,
  input  logic [7:0] in0,
  input  logic [3:0] digit_en,
  input  logic [2:0] bright,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int TW = $clog2(SLOT_M);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_M - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(SLOT_M - BLANK_M - 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [2:0]    phase, phase_nxt;
  logic [7:0]    pat, pat_nxt;
  logic          en, en_nxt;
  logic [2:0]    bri, bri_nxt;
  logic [7:0]    sel_pat;
  logic [3:0]    an_nxt;
  logic [7:0]    sseg_nxt;
  logic          tick_nxt;

  always_comb begin
    sel_pat = in0;
    case (idx)
      2'd0:    sel_pat = in0;
      2'd1:    sel_pat = in1;
      2'd2:    sel_pat = in2;
      default: sel_pat = in3;
    endcase
  end

  // Next-state logic. Outputs are derived from the *next* state so the
  // registered an/sseg/frame_tick change on the same edge as the FSM.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    phase_nxt = phase;
    pat_nxt   = pat;
    en_nxt    = en;
    bri_nxt   = bri;
    tick_nxt  = 1'b0;
    an_nxt    = 4'hF;
    sseg_nxt  = 8'hFF;

    case (state)
      S_BLANK: begin
        if (timer == BLANK_LAST) begin
          // Snapshot the slot's inputs so mid-slot changes cannot glitch it.
          state_nxt = S_ON;
          timer_nxt = '0;
          phase_nxt = 3'd0;
          pat_nxt   = sel_pat;
          en_nxt    = digit_en[idx];
          bri_nxt   = bright;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        if (timer == ON_LAST) begin
          state_nxt = S_BLANK;
          timer_nxt = '0;
          idx_nxt   = idx + 2'd1;
          tick_nxt  = (idx == 2'd3);
        end else begin
          timer_nxt = timer + 1'b1;
          phase_nxt = phase + 3'd1;
        end
      end
    endcase

    if (state_nxt == S_ON && en_nxt && (phase_nxt <= bri_nxt)) begin
      an_nxt   = ~(4'b0001 << idx_nxt);
      sseg_nxt = pat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BLANK;
      timer      <= '0;
      idx        <= 2'd0;
      phase      <= 3'd0;
      pat        <= 8'd0;
      en         <= 1'b0;
      bri        <= 3'd0;
      an         <= 4'hF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      idx        <= idx_nxt;
      phase      <= phase_nxt;
      pat        <= pat_nxt;
      en         <= en_nxt;
      bri        <= bri_nxt;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_led_scan_sched.sv
module tb_led_scan_sched;

  localparam int SLOT  = 20;
  localparam int BLANK = 4;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] digit_en;
  logic [2:0] bright;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  led_scan_sched #(.SLOT_M(SLOT), .BLANK_M(BLANK)) dut (
    .clk(clk), .reset(reset),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .digit_en(digit_en), .bright(bright),
    .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n = 0;           // index of the most recently observed cycle since reset
  int tick_cnt = 0;
  int last_tick = -1;

  logic [7:0] m_pat = 8'd0;
  logic       m_en = 1'b0;
  logic [2:0] m_bri = 3'd0;

  // Reference: slot position is pure arithmetic on the cycle count.
  task automatic calc(input int c, output exp_t e);
    int pos, d, ph;
    pos = c % SLOT;
    d   = (c / SLOT) % 4;
    e.an   = 4'hF;
    e.sseg = 8'hFF;
    e.tick = (c > 0 && pos == 0 && d == 0);
    if (pos >= BLANK) begin
      if (pos == BLANK) begin
        case (d)
          0: m_pat = in0;
          1: m_pat = in1;
          2: m_pat = in2;
          default: m_pat = in3;
        endcase
        m_en  = digit_en[d];
        m_bri = bright;
      end
      ph = (pos - BLANK) % 8;
      if (m_en && ph <= int'(m_bri)) begin
        e.an   = 4'hF & ~(4'b0001 << d);
        e.sseg = m_pat;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, n, obs, exp_v);
    end
  endtask

  task automatic step();
    exp_t e, got;
    calc(n + 1, e);
    q.push_back(e);
    @(negedge clk);
    n++;
    got = q.pop_front();
    cmp("an", 32'(an), 32'(got.an));
    cmp("sseg", 32'(sseg), 32'(got.sseg));
    cmp("frame_tick", 32'(frame_tick), 32'(got.tick));
    cmp("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      if (last_tick >= 0) cmp("tick_spacing", 32'(n - last_tick), 32'(FRAME));
      last_tick = n;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    n = 0;
    cmp("rst_an", 32'(an), 32'h0000000F);
    cmp("rst_sseg", 32'(sseg), 32'h000000FF);
    cmp("rst_tick", 32'(frame_tick), 32'd0);
    reset = 1'b0;
    tick_cnt = 0;
    last_tick = -1;
  endtask

  initial begin
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
    digit_en = 4'hF;
    bright = 3'd7;
    @(negedge clk);
    do_reset();

    // Full brightness, digits 0 and 1
    run(2 * SLOT);

    // Half brightness for the rest of the frame and the next one
    bright = 3'd3;
    run(FRAME);

    // Change digit 0 pattern in the middle of its ON phase
    while (n % FRAME != 10) step();
    in0 = 8'hA4;
    run(FRAME);

    // Digits 1 and 3 disabled, then all disabled: frame cadence unchanged
    bright = 3'd7;
    digit_en = 4'b0101;
    run(2 * FRAME);
    digit_en = 4'b0000;
    run(FRAME);

    // Free run 400 cycles from a fresh reset: exactly 5 frame ticks
    digit_en = 4'hF;
    in0 = 8'hC0;
    do_reset();
    run(400);
    cmp("tick_count", 32'(tick_cnt), 32'd5);

    // Reset during digit 2 ON cycle 7, then a clean restart
    do_reset();
    while (n < 2 * SLOT + BLANK + 7) step();
    do_reset();
    run(SLOT + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scan_sched.md
LED_SCAN_SCHED -- requirements
Module: led_scan_sched

Interface
REQ-001 SHALL have parameter SLOT_M, default 50_000: clocks per digit slot, blank time included.
REQ-002 SHALL have parameter BLANK_M, default 500: blanking clocks at the start of each slot.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports in3, in2, in1, in0  input  8 each  per-digit segment patterns, active-low, bit order dp g f e d c b a.
REQ-006 SHALL have port digit_en  input  4  per-digit enable; bit i = digit i.
REQ-007 SHALL have port bright  input  3  brightness duty: lit 8'd(bright+1) of every 8 ON cycles.
REQ-008 SHALL have port an  output  4  digit anodes, active-low, registered.
REQ-009 SHALL have port sseg  output  8  segment bus, active-low, registered.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at the end of each full 4-digit scan, registered.

Function
REQ-011 SHALL time-share the single sseg bus among 4 digits in fixed order 0,1,2,3,0,... with one slot per digit.
REQ-012 SHALL implement a 2-state FSM, BLANK and ON, and a slot timer of width $clog2(SLOT_M).
REQ-013 SHALL stay in BLANK for exactly BLANK_M cycles (timer 0..BLANK_M-1), then enter ON with timer cleared.
REQ-014 SHALL stay in ON for exactly ON_M = SLOT_M-BLANK_M cycles, then enter BLANK, clear the timer and advance the digit index modulo 4 (3 wraps to 0).
REQ-015 SHALL drive an=4'hF and sseg=8'hFF during every BLANK cycle.
REQ-016 SHALL latch the selected digit's pattern, its digit_en bit and bright on the BLANK->ON transition edge and hold them for the whole ON phase; input changes mid-slot SHALL NOT affect the current slot.
REQ-017 SHALL keep a 3-bit PWM phase, cleared on ON entry and incremented every ON cycle with wrap 7->0.
REQ-018 SHALL, in an ON cycle, drive an with only bit idx low and sseg = latched pattern when the latched enable is 1 and phase <= latched bright; otherwise an=4'hF and sseg=8'hFF.
REQ-019 SHALL give a disabled digit its full slot dark, so frame period = 4*SLOT_M cycles for every digit_en value, including 4'b0000.
REQ-020 SHALL register an, sseg and frame_tick so they change on the same edge as the FSM state they reflect; there SHALL be no combinational path from inputs to outputs.
REQ-021 SHALL assert frame_tick for exactly one cycle: the first BLANK cycle after ON of digit 3.
REQ-022 SHALL never drive more than one an bit low in any cycle.
REQ-023 SHALL require BLANK_M >= 1 and SLOT_M >= BLANK_M+8; behaviour outside this range is undefined.

Reset
REQ-024 SHALL, on reset high at a clock edge, set FSM=BLANK, timer=0, digit index=0, phase=0, latched values=0, an=4'hF, sseg=8'hFF, frame_tick=0, regardless of current phase.
REQ-025 SHALL start the first slot (digit 0 BLANK, cycle 0) on the first edge with reset low.

Verification (SLOT_M=20, BLANK_M=4, ON_M=16)
REQ-026 Reset release, digit_en=4'hF, bright=7, in0=8'hC0, in1=8'hF9 -> an=F for 4 cycles, an=4'b1110/sseg=C0 for 16 cycles, an=F for 4 cycles, then an=4'b1101/sseg=F9 for 16 cycles.
REQ-027 bright=3 -> in each ON phase an low for phases 0-3 and high for 4-7, twice, so 8 lit of 16 cycles.
REQ-028 digit_en=4'b0101 -> digits 1 and 3 slots fully an=F/sseg=FF; frame_tick period still 80 cycles.
REQ-029 Free run 400 cycles -> frame_tick high exactly 5 times, spaced 80 cycles apart, each on the first BLANK cycle after digit 3 ON; an never has two low bits.
REQ-030 in0 changes C0->A4 mid digit-0 ON -> sseg stays C0 to slot end; A4 appears in the next digit-0 slot.
REQ-031 reset pulse during digit 2 ON cycle 7 -> next cycle an=F, sseg=FF, frame_tick=0; scan restarts at digit 0 with 4 blank cycles.
